branch_predictor_bht: RTL and testbench

- Parametrised branch history table (BHT) that supplies the `predict_taken` hint for conditional branches in fetch/decode.
- Successor to the single-bit combinational predict output of the optimized branch unit.
- Holds an array of N-bit saturating counters, optionally indexed gshare-style with a global history register (GHR).
- Trained by resolved branches from execute; keeps a mispredict statistics counter.

---
 rtl/branch_predictor_bht.sv | 181 ++++++++++++++++++
 tb/tb_branch_predictor_bht.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// ============================================================================
//  Module   : branch_predictor_bht
//  Purpose  : Branch history table of saturating counters that supplies the
//             predict_taken hint for conditional branches. The table can be
//             indexed bimodally (PC bits only) or gshare-style (PC bits XOR a
//             global history register). Resolved branches train the table,
//             and mispredicted branches are counted.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             flush_req           - clear history and re-initialise the table
//             ready               - table initialised, lookups/updates honoured
//             lookup_valid/pc     - lookup request and branch PC
//             predict_taken       - combinational prediction
//             lookup_index        - index used, carried down the pipeline
//             update_valid/index/taken/predicted - resolved branch training
//             mispredict_count    - running count of mispredicted branches
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_bht #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_req,
    output logic                        ready,
    input  logic                        lookup_valid,
    input  logic [XLEN-1:0]             lookup_pc,
    output logic                        predict_taken,
    output logic [$clog2(ENTRIES)-1:0]  lookup_index,
    input  logic                        update_valid,
    input  logic [$clog2(ENTRIES)-1:0]  update_index,
    input  logic                        update_taken,
    input  logic                        update_predicted,
    output logic [31:0]                 mispredict_count
);

    localparam int                  c_idx     = $clog2(ENTRIES);
    // Weakly-not-taken: the largest value whose MSB is still clear.
    localparam logic [CTR_BITS-1:0] c_ctr_wnt = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_ctr_max = '1;
    localparam logic [CTR_BITS-1:0] c_ctr_min = '0;
    localparam logic [c_idx-1:0]    c_last    = c_idx'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_idx-1:0]    r_ptr;
    logic                r_ready;
    logic [31:0]         r_mis_cnt;
    logic [CTR_BITS-1:0] r_ctr [ENTRIES];

    logic [c_idx-1:0]    w_ghr_ext;
    logic                w_upd_en;
    logic                w_mispredict;
    logic [CTR_BITS-1:0] w_ctr_cur;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_unused_pc;

    // A flush drops the training write, but a mispredict seen while ready is
    // still counted so statistics survive pipeline flushes.
    assign w_upd_en     = update_valid & r_ready & ~flush_req;
    assign w_mispredict = update_valid & r_ready & (update_taken ^ update_predicted);

    // ------------------------------------------------------------------------
    // Global history register (absent in bimodal configuration)
    // ------------------------------------------------------------------------
    generate
        if (GHR_BITS > 0) begin : g_ghr
            logic [GHR_BITS-1:0] r_ghr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ghr <= '0;
                end else if (flush_req) begin
                    r_ghr <= '0;
                end else if (w_upd_en) begin
                    // Shift left, newest outcome enters at the LSB.
                    r_ghr <= GHR_BITS'({r_ghr, update_taken});
                end
            end

            always_comb begin
                w_ghr_ext                 = '0;
                w_ghr_ext[GHR_BITS-1:0]   = r_ghr;
            end
        end else begin : g_no_ghr
            assign w_ghr_ext = '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Lookup path: word-aligned PC bits hashed with history, zero latency
    // ------------------------------------------------------------------------
    assign lookup_index  = lookup_pc[c_idx+1:2] ^ w_ghr_ext;
    assign predict_taken = r_ready & lookup_valid & r_ctr[lookup_index][CTR_BITS-1];
    assign w_unused_pc   = ^{lookup_pc[XLEN-1:c_idx+2], lookup_pc[1:0]};

    // ------------------------------------------------------------------------
    // Saturating counter next value for the entry being trained
    // ------------------------------------------------------------------------
    assign w_ctr_cur = r_ctr[update_index];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (update_taken) begin
            if (w_ctr_cur != c_ctr_max) begin
                w_ctr_next = w_ctr_cur + CTR_BITS'(1);
            end
        end else begin
            if (w_ctr_cur != c_ctr_min) begin
                w_ctr_next = w_ctr_cur - CTR_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Counter array: RAM-style, no reset. Cleared one entry per cycle by the
    // INIT sweep; otherwise written only by honoured updates. Reads above see
    // the pre-write value, giving read-before-write on same-index collisions.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_ctr[r_ptr] <= c_ctr_wnt;
        end else if (w_upd_en) begin
            r_ctr[update_index] <= w_ctr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM, sweep pointer, ready flag and mispredict statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_ptr     <= '0;
            r_ready   <= 1'b0;
            r_mis_cnt <= '0;
        end else begin
            if (w_mispredict) begin
                r_mis_cnt <= r_mis_cnt + 32'd1;
            end

            if (flush_req) begin
                r_state <= ST_INIT;
                r_ptr   <= '0;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        r_ptr <= r_ptr + c_idx'(1);
                        if (r_ptr == c_last) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        r_ready <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_INIT;
                        r_ptr   <= '0;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready            = r_ready;
    assign mispredict_count = r_mis_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
// ============================================================================
//  Module   : tb_branch_predictor_bht
//  Purpose  : Scoreboard bench for branch_predictor_bht. Two instances (bimodal
//             and 2-bit history) share stimulus; a reference model predicts
//             every cycle's outputs, which a monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_bht;

    localparam int c_entries = 64;
    localparam int c_wnt     = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_req = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_valid = 1'b0;
    logic [5:0]  update_index = '0;
    logic        update_taken = 1'b0;
    logic        update_predicted = 1'b0;

    logic        ready0, ready2, pt0, pt2;
    logic [5:0]  li0, li2;
    logic [31:0] mc0, mc2;

    always #5 clk = ~clk;

    branch_predictor_bht #(.XLEN(32), .ENTRIES(c_entries), .CTR_BITS(2), .GHR_BITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .ready(ready0),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .predict_taken(pt0),
        .lookup_index(li0), .update_valid(update_valid), .update_index(update_index),
        .update_taken(update_taken), .update_predicted(update_predicted),
        .mispredict_count(mc0)
    );

    branch_predictor_bht #(.XLEN(32), .ENTRIES(c_entries), .CTR_BITS(2), .GHR_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .ready(ready2),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .predict_taken(pt2),
        .lookup_index(li2), .update_valid(update_valid), .update_index(update_index),
        .update_taken(update_taken), .update_predicted(update_predicted),
        .mispredict_count(mc2)
    );

    typedef struct {
        bit          rdy;
        logic [31:0] cnt;
        logic [5:0]  i0;
        bit          p0;
        logic [5:0]  i2;
        bit          p2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: table contents, readiness, history and statistics.
    int          m_ctr0 [c_entries];
    int          m_ctr2 [c_entries];
    bit          m_ready;
    int          m_left;
    int          m_ghr;
    logic [31:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int f_idx(input logic [31:0] pc, input int g);
        return ((pc >> 2) % c_entries) ^ g;
    endfunction

    function automatic int f_sat(input int v, input bit t);
        if (t) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = c_entries;
        m_ghr   = 0;
        m_cnt   = '0;
    endtask

    // One rising edge with rst_n high.
    task automatic model_edge(input bit uv, input int ui, input bit ut, input bit up, input bit fl);
        if (uv && m_ready && (ut != up)) m_cnt = m_cnt + 32'd1;
        if (fl) begin
            m_ready = 1'b0;
            m_left  = c_entries;
            m_ghr   = 0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int k = 0; k < c_entries; k++) begin
                    m_ctr0[k] = c_wnt;
                    m_ctr2[k] = c_wnt;
                end
            end
        end else if (uv) begin
            m_ctr0[ui] = f_sat(m_ctr0[ui], ut);
            m_ctr2[ui] = f_sat(m_ctr2[ui], ut);
            m_ghr      = ((m_ghr << 1) | int'(ut)) & 3;
        end
    endtask

    task automatic step(input bit rn, input bit lv, input logic [31:0] pc,
                        input bit uv, input int ui, input bit ut, input bit up,
                        input bit fl);
        exp_t e;
        int   a0, a2;
        @(negedge clk);
        rst_n            = rn;
        lookup_valid     = lv;
        lookup_pc        = pc;
        update_valid     = uv;
        update_index     = 6'(ui);
        update_taken     = ut;
        update_predicted = up;
        flush_req        = fl;
        if (!rn) model_reset();
        a0    = f_idx(pc, 0);
        a2    = f_idx(pc, m_ghr);
        e.rdy = m_ready;
        e.cnt = m_cnt;
        e.i0  = 6'(a0);
        e.i2  = 6'(a2);
        e.p0  = m_ready && lv && (m_ctr0[a0] >= 2);
        e.p2  = m_ready && lv && (m_ctr2[a2] >= 2);
        q.push_back(e);
        if (rn) model_edge(uv, ui, ut, up, fl);
    endtask

    task automatic idle(input int n, input logic [31:0] pc);
        for (int k = 0; k < n; k++) step(1, 1, pc, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the DUTs present against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ready0",     32'(ready0), 32'(e.rdy));
                chk("ready2",     32'(ready2), 32'(e.rdy));
                chk("mispred0",   mc0,         e.cnt);
                chk("mispred2",   mc2,         e.cnt);
                chk("index0",     32'(li0),    32'(e.i0));
                chk("index2",     32'(li2),    32'(e.i2));
                chk("predict0",   32'(pt0),    32'(e.p0));
                chk("predict2",   32'(pt2),    32'(e.p2));
            end
        end
    end

    initial begin
        logic [31:0] pc;
        model_reset();

        // Reset, then sweep with a lookup of 0x104 held
        for (int k = 0; k < 3; k++) step(0, 1, 32'h104, 0, 0, 0, 0, 0);
        idle(68, 32'h104);

        // Two taken/mispredicted updates on index 1
        step(1, 1, 32'h104, 1, 1, 1, 0, 0);
        step(1, 1, 32'h104, 1, 1, 1, 0, 0);
        idle(2, 32'h104);

        // Saturation on index 5: five taken, four not-taken
        for (int k = 0; k < 5; k++) step(1, 1, 32'h114, 1, 5, 1, 1, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 32'h114, 1, 5, 0, 0, 0);
        idle(2, 32'h114);

        // History: taken then not-taken, then lookup 0x104
        step(1, 1, 32'h104, 1, 7, 1, 1, 0);
        step(1, 1, 32'h104, 1, 7, 0, 0, 0);
        idle(2, 32'h104);

        // Flush together with a mispredicting update; updates during INIT dropped
        step(1, 1, 32'h104, 1, 2, 1, 0, 1);
        for (int k = 0; k < 10; k++) step(1, 1, 32'h104, 1, 1, 1, 0, 0);
        idle(60, 32'h104);

        // Same-cycle lookup and update on index 1 (counter at 1)
        step(1, 1, 32'h104, 1, 1, 1, 0, 0);
        idle(2, 32'h104);

        // Flush, then reset mid-sweep restarts the full sweep
        step(1, 1, 32'h104, 0, 0, 0, 0, 1);
        idle(20, 32'h104);
        step(0, 1, 32'h104, 0, 0, 0, 0, 0);
        step(0, 1, 32'h104, 0, 0, 0, 0, 0);
        idle(70, 32'h104);

        // Randomised traffic with occasional flush and reset
        for (int k = 0; k < 3000; k++) begin
            pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            step(($urandom % 1000) != 0,
                 ($urandom % 4) != 0,
                 pc,
                 ($urandom % 2) != 0,
                 ($urandom % 2) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 63)),
                 ($urandom % 2) != 0,
                 ($urandom % 2) != 0,
                 ($urandom % 300) == 0);
        end

        @(negedge clk);
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        flush_req    = 1'b0;
        #5;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
